// File: rtl/uart_tx_scheduler_if.sv
// Bundles the CPU, debug and sender handshakes of the UART word scheduler.
// Handshake rule: a word moves on a posedge where valid && ready; the requester holds data/nbytes stable while valid is high and unaccepted.
interface uart_tx_scheduler_if;
    logic [31:0] cpu_data;
    logic [1:0]  cpu_nbytes;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [31:0] dbg_data;
    logic [1:0]  dbg_nbytes;
    logic        dbg_valid;
    logic        dbg_ready;
    logic        sender_ready;
    logic [7:0]  sender_data;
    logic        sender_enable;

    modport master (
        output cpu_data, cpu_nbytes, cpu_valid,
        input  cpu_ready,
        output dbg_data, dbg_nbytes, dbg_valid,
        input  dbg_ready,
        output sender_ready,
        input  sender_data, sender_enable
    );

    modport slave (
        input  cpu_data, cpu_nbytes, cpu_valid,
        output cpu_ready,
        input  dbg_data, dbg_nbytes, dbg_valid,
        output dbg_ready,
        input  sender_ready,
        output sender_data, sender_enable
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one byte-wide UART sender between a FIFO-buffered CPU path and a debug holding register,
// arbitrating round-robin per word and emitting bytes most-significant selected byte first.
module uart_tx_scheduler #(
    parameter int FIFO_AW = 2
) (
    input  logic                 CLK,
    input  logic                 reset,
    uart_tx_scheduler_if.slave   bus,
    output logic                 busy,
    output logic [15:0]          tx_count,
    output logic [1:0]           fsm_state
);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]         state;
    logic [33:0]        fifo_mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic               fifo_full;
    logic               fifo_empty;
    logic [33:0]        dbg_word;
    logic               dbg_full;
    logic               last_grant;   // 1 = debug was granted last
    logic [31:0]        word_q;
    logic [1:0]         byte_cnt;
    logic [7:0]         data_q;
    logic [15:0]        tx_count_q;

    logic               push;
    logic               dbg_cap;
    logic               grant_any;
    logic               grant_cpu;
    logic               pop;
    logic               strobe;
    logic [33:0]        grant_entry;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    assign bus.cpu_ready = reset && !fifo_full;
    assign bus.dbg_ready = reset && !dbg_full;

    assign push      = bus.cpu_valid && bus.cpu_ready;
    assign dbg_cap   = bus.dbg_valid && bus.dbg_ready;
    assign grant_any = (state == S_IDLE) && (!fifo_empty || dbg_full);
    // CPU wins unless debug is also pending and the CPU had the previous word.
    assign grant_cpu = !fifo_empty && (!dbg_full || last_grant);
    assign pop       = grant_any && grant_cpu;
    assign grant_entry = grant_cpu ? fifo_mem[rd_ptr[FIFO_AW-1:0]] : dbg_word;

    // Reset gates the strobe immediately so a word cut by reset issues nothing more.
    assign strobe            = reset && (state == S_SEND) && bus.sender_ready;
    assign bus.sender_enable = strobe;
    assign bus.sender_data   = data_q;
    assign busy              = reset && (state != S_IDLE);
    assign tx_count          = tx_count_q;
    assign fsm_state         = state;

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {bus.cpu_nbytes, bus.cpu_data};
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dbg_word   <= '0;
            dbg_full   <= 1'b0;
            last_grant <= 1'b1;
            word_q     <= '0;
            byte_cnt   <= '0;
            data_q     <= '0;
            tx_count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (dbg_cap) begin
                dbg_word <= {bus.dbg_nbytes, bus.dbg_data};
                dbg_full <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        word_q     <= grant_entry[31:0];
                        byte_cnt   <= grant_entry[33:32];
                        data_q     <= pick_byte(grant_entry[31:0], grant_entry[33:32]);
                        last_grant <= !grant_cpu;
                        if (!grant_cpu) dbg_full <= 1'b0;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (strobe) begin
                        tx_count_q <= tx_count_q + 16'd1;
                        if (byte_cnt == 2'd0) begin
                            state <= S_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt - 2'd1;
                            data_q   <= pick_byte(word_q, byte_cnt - 2'd1);
                            state    <= S_GAP;
                        end
                    end
                end
                S_GAP:   state <= S_SEND;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
